// File: rtl/ccff_bitstream_loader.sv
// Serializes host bitstream words onto a fabric ccff chain. An optional second
// pass reads back the previous contents from ccff_tail and counts mismatches.
module ccff_bitstream_loader #(
  parameter int CHAIN_LEN = 40,
  parameter int WORD_W    = 8,
  parameter int CNT_W     = 16
) (
  input  logic              prog_clk,
  input  logic              prog_rst_n,
  input  logic              start,
  input  logic              verify,
  input  logic [WORD_W-1:0] word_data,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              ccff_head,
  input  logic              ccff_tail,
  output logic              ccff_shift_en,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [CNT_W-1:0]  mismatch_cnt
);
  localparam int NWORDS = (CHAIN_LEN + WORD_W - 1) / WORD_W;
  localparam int BC_W   = $clog2(CHAIN_LEN + 1);
  localparam int BL_W   = $clog2(WORD_W + 1);
  localparam int WL_W   = $clog2(NWORDS + 1);

  localparam logic [BC_W-1:0] LAST_BIT   = BC_W'(CHAIN_LEN - 1);
  localparam logic [BC_W-1:0] CHAIN_END  = BC_W'(CHAIN_LEN);
  localparam logic [BL_W-1:0] FULL_WORD  = BL_W'(WORD_W);
  localparam logic [WL_W-1:0] PASS_WORDS = WL_W'(NWORDS);

  typedef enum logic [1:0] {IDLE, LOAD, VERIFY, DONE} state_t;

  state_t            state;
  logic [WORD_W-1:0] buf_q;
  logic [BL_W-1:0]   bits_left;
  logic [BC_W-1:0]   bit_cnt;
  logic [WL_W-1:0]   words_left;
  logic              verify_q;

  logic             streaming, accept, pass_end, mismatch;
  logic [CNT_W-1:0] mm_next;

  assign streaming     = (state == LOAD) || (state == VERIFY);
  assign ccff_shift_en = streaming && (bits_left != '0) && (bit_cnt < CHAIN_END);
  // Refill on the last shift of the current word so consecutive words stream gaplessly.
  assign word_ready    = streaming && (words_left != '0) &&
                         ((bits_left == '0) || ((bits_left == BL_W'(1)) && ccff_shift_en));
  assign ccff_head     = (bits_left != '0) && buf_q[WORD_W-1];
  assign accept        = word_valid && word_ready;
  assign pass_end      = ccff_shift_en && (bit_cnt == LAST_BIT);
  assign mismatch      = (state == VERIFY) && ccff_shift_en && (ccff_tail != ccff_head);
  assign mm_next       = (mismatch && (mismatch_cnt != '1)) ? mismatch_cnt + CNT_W'(1)
                                                            : mismatch_cnt;

  always_ff @(posedge prog_clk or negedge prog_rst_n) begin
    if (!prog_rst_n) begin
      state        <= IDLE;
      buf_q        <= '0;
      bits_left    <= '0;
      bit_cnt      <= '0;
      words_left   <= '0;
      verify_q     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      mismatch_cnt <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            verify_q     <= verify;
            mismatch_cnt <= '0;
            error        <= 1'b0;
            bit_cnt      <= '0;
            bits_left    <= '0;
            words_left   <= PASS_WORDS;
            busy         <= 1'b1;
            state        <= LOAD;
          end
        end
        LOAD, VERIFY: begin
          mismatch_cnt <= mm_next;
          if (accept) begin
            buf_q      <= word_data;
            bits_left  <= FULL_WORD;
            words_left <= words_left - WL_W'(1);
          end else if (ccff_shift_en) begin
            buf_q     <= buf_q << 1;
            bits_left <= bits_left - BL_W'(1);
          end
          if (ccff_shift_en) bit_cnt <= bit_cnt + BC_W'(1);
          // Last chain bit: drop any leftover low bits of the final word.
          if (pass_end) begin
            bits_left  <= '0;
            bit_cnt    <= '0;
            words_left <= PASS_WORDS;
            if (state == LOAD && verify_q) begin
              state <= VERIFY;
            end else begin
              state <= DONE;
              done  <= 1'b1;
              error <= (mm_next != '0);
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/ccff_bitstream_loader.md
Name: ccff_bitstream_loader

Overview:
- Writer side of the configuration-chain (ccff) protocol: accepts bitstream words from the host or config controller and serializes them onto ccff_head of a fabric ccff chain of CHAIN_LEN flops.
- The chain has no local enable, so the block drives ccff_shift_en, which feeds the external prog_clk gate of the fabric chain.
- Optional verify pass: the host resends the same bitstream, and the block compares ccff_tail against it bit-for-bit.

Parameters:
- CHAIN_LEN, 40, number of configuration bits (flops) in the attached ccff chain; must be ≥1.
- WORD_W, 8, width of input bitstream words; must be ≥1.
- CNT_W, 16, width of the mismatch counter.

Ports:
- prog_clk  input  1  block clock; the fabric chain is clocked by prog_clk gated with ccff_shift_en.
- prog_rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request to begin a pass sequence; sampled only in IDLE.
- verify  input  1  sampled with start; 1 = load pass followed by verify pass.
- word_data  input  WORD_W  bitstream word, MSB shifted first.
- word_valid  input  1  word_data valid.
- word_ready  output  1  block accepts word_data this cycle.
- ccff_head  output  1  serial config bit to chain head.
- ccff_tail  input  1  serial bit from chain tail.
- ccff_shift_en  output  1  chain shifts on the next prog_clk rising edge.
- busy  output  1  high from LOAD entry until the DONE state exits.
- done  output  1  one-cycle pulse at end of sequence.
- error  output  1  mismatch_cnt≠0; held until next accepted start.
- mismatch_cnt  output  CNT_W  saturating count of verify mismatches.

Behaviour:
- Reset (async, prog_rst_n=0):
  - State goes to IDLE.
  - word_ready, ccff_head, ccff_shift_en, busy, done, error = 0; mismatch_cnt = 0.
  - bit buffer is empty and bit_cnt = 0.
  - Reset mid-pass abandons the pass; chain contents are undefined.
- States: IDLE, LOAD, VERIFY, DONE.
- IDLE:
  - start=1 latches verify, clears mismatch_cnt/error and bit_cnt, then transitions to LOAD.
  - start is ignored in all other states.
- Word buffer: WORD_W-bit shift register plus bits_left counter.
  - word_ready = state∈{LOAD,VERIFY} && (bits_left==0 || (bits_left==1 && ccff_shift_en)) && remaining-word count > 0.
  - Accept when word_valid && word_ready.
  - First bit of an accepted word appears on ccff_head the cycle after acceptance. Back-to-back valid words therefore shift gaplessly.
- Shift cycle rules:
  - ccff_shift_en = state∈{LOAD,VERIFY} && bits_left>0 && bit_cnt<CHAIN_LEN.
  - ccff_head is the buffer MSB (0 when buffer empty).
  - On each shift-cycle edge: buffer shifts left, bits_left--, bit_cnt++.
- Pass end: when bit_cnt reaches CHAIN_LEN, the pass ends.
  - Unused low bits of the last word are discarded (bits_left forced to 0).
  - Words per pass = ceil(CHAIN_LEN/WORD_W); no word is accepted beyond that.
- LOAD end: go to VERIFY (bit_cnt=0) if the latched verify=1, else go to DONE.
- VERIFY:
  - Same stream rules as LOAD.
  - On each shift cycle, ccff_tail is compared with ccff_head. During shift k of this pass the tail holds bit k of the previous pass.
  - Inequality increments mismatch_cnt, saturating at 2^CNT_W−1.
  - At end of pass, go to DONE.
- DONE: lasts one cycle; done=1; error = (mismatch_cnt≠0); busy=0 next cycle; return to IDLE.
- word_valid with word_ready=0 holds data stable (standard valid/ready; block never drops an accepted word).
- Backpressure from the host (word_valid=0 with buffer empty): ccff_shift_en=0 and the chain holds.

Test Plan:
- Test harness: behavioural N-flop chain clocked when ccff_shift_en=1.
- CHAIN_LEN=16, WORD_W=8, verify=0, words 0xA5,0x3C gapless.
  - ccff_shift_en high 16 consecutive cycles.
  - Head sequence 1010010100111100.
  - done pulse; error=0; model chain matches.
- CHAIN_LEN=12, words 0xFF,0x0F.
  - Exactly 2 words accepted; 12 shifts: 11111111 0000.
  - Low nibble discarded; word_ready stays 0 afterwards until next start.
- CHAIN_LEN=16, verify=1, send 0xA5,0x3C twice.
  - 32 shift cycles; mismatch_cnt=0, error=0, single done pulse.
- Same as previous, but flip model flop holding bit 3 before VERIFY.
  - mismatch_cnt=1, error=1 after done.
  - Next start clears both.
- Host inserts 3 idle cycles between words.
  - ccff_shift_en low exactly on gap cycles.
  - Head sequence unchanged; no lost or duplicated bits.
- Assert prog_rst_n=0 after 5 shifts of the first pass.
  - All outputs 0 immediately.
  - A new start restarts from bit 0 and completes a full 16-bit load.
